// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and defaults for the fetch-stage PC sequencer.
package pc_seq_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_VECTOR_D = 32'h0000_0000;
  localparam int unsigned PC_STEP_D = 4;
  typedef enum logic [2:0] {BOOT, FETCH, WAIT, REDIRECT, HALT} state_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and IMEM/IF-ID outputs of the fetch sequencer.
// fault_o exists only when PC_ALIGN_CHECK_EN is defined.
interface pc_sequencer_if;
  import pc_seq_pkg::*;
  logic            stall_i;
  logic            br_taken_i;
  logic [PC_W-1:0] br_target_i;
  logic            imem_ready_i;
  logic            imem_req_o;
  logic [PC_W-1:0] pc_o;
  logic [PC_W-1:0] pc_plus4_o;
  logic            if_valid_o;
  logic            flush_o;
`ifdef PC_ALIGN_CHECK_EN
  logic            fault_o;
`endif
  modport master (
    input  stall_i, br_taken_i, br_target_i, imem_ready_i,
`ifdef PC_ALIGN_CHECK_EN
    output fault_o,
`endif
    output imem_req_o, pc_o, pc_plus4_o, if_valid_o, flush_o
  );
  modport slave (
    output stall_i, br_taken_i, br_target_i, imem_ready_i,
`ifdef PC_ALIGN_CHECK_EN
    input  fault_o,
`endif
    input  imem_req_o, pc_o, pc_plus4_o, if_valid_o, flush_o
  );
endinterface

// File: rtl/pc_incr.sv
// pc_incr: combinational PC + step, carry discarded.
module pc_incr
  import pc_seq_pkg::*;
#(
  parameter int unsigned STEP = PC_STEP_D
) (
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next
);
  assign pc_next = pc + PC_W'(STEP);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register, branch redirect, stall and IMEM handshake.
// Define PC_ALIGN_CHECK_EN to trap misaligned branch targets into a sticky fault/HALT.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_D,
  parameter int unsigned     PC_STEP      = PC_STEP_D
) (
  input logic            clk,
  input logic            reset_n,
  pc_sequencer_if.master bus
);
  state_e          state, state_n;
  logic [PC_W-1:0] pc, pc_n, pc_inc, tgt;
  logic            valid, valid_n, flush, flush_n, redirect, misaligned;

  pc_incr #(.STEP(PC_STEP)) u_incr (.pc(pc), .pc_next(pc_inc));

`ifdef PC_ALIGN_CHECK_EN
  logic fault, fault_n;
  assign tgt        = bus.br_target_i;
  assign misaligned = |bus.br_target_i[1:0];
  assign fault_n    = fault | (redirect & misaligned);
  assign bus.fault_o = fault;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) fault <= 1'b0;
    else          fault <= fault_n;
`else
  assign tgt        = bus.br_target_i & ~PC_W'(3);
  assign misaligned = 1'b0;
`endif

  // Branches are honoured while fetching or in the bubble, never in BOOT/HALT.
  assign redirect = bus.br_taken_i && state != BOOT && state != HALT;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = 1'b0;
    flush_n = 1'b0;
    if (redirect) begin
      pc_n    = tgt;
      flush_n = 1'b1;
      state_n = misaligned ? HALT : REDIRECT;
    end else if (state == BOOT || state == REDIRECT) begin
      state_n = FETCH;
    end else if ((state == FETCH || state == WAIT) && !bus.stall_i) begin
      pc_n    = bus.imem_ready_i ? pc_inc : pc;
      valid_n = bus.imem_ready_i;
      state_n = bus.imem_ready_i ? FETCH : WAIT;
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
      valid <= 1'b0;
      flush <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      valid <= valid_n;
      flush <= flush_n;
    end

  assign bus.imem_req_o = state == FETCH || state == WAIT;
  assign bus.pc_o       = pc;
  assign bus.pc_plus4_o = pc_inc;
  assign bus.if_valid_o = valid;
  assign bus.flush_o    = flush;
endmodule
